// File: rtl/lfsr_fib_gen.sv
// Fibonacci LFSR pseudo-random bit generator with valid/ready output.
// Feedback is the XOR of the state bits selected by TAPS. The state shifts
// right by one on each accepted bit. Seeds can be loaded at any time, and a
// zero seed is replaced by RESET_SEED so the register never locks up.
// Optional feature macro: LFSR_PERIOD_CNT_EN adds period_cnt / period_done.
module lfsr_fib_gen #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = 8'h1D,
    parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [WIDTH-1:0] state,
    output logic             seed_err
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0] period_cnt,
    output logic             period_done
`endif
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             fire;
    logic             fb;
    logic [WIDTH-1:0] shift_val;
    logic             seed_zero;
    logic [WIDTH-1:0] load_val;

    // Feedback bit and the right-shifted successor of the current state
    always_comb begin
        fb        = ^(state_q & TAPS);
        shift_val = {fb, state_q[WIDTH-1:1]};
    end

    // A zero seed would lock the register at zero; substitute the reset seed
    always_comb begin
        seed_zero = (seed == '0);
        load_val  = seed_zero ? RESET_SEED : seed;
    end

    assign fire = valid_q & out_ready;

    // Next-state selection: load wins over shift, stall holds the state
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        valid_d = en & ~seed_load;
        if (seed_load) begin
            state_d = load_val;
            err_d   = seed_zero;
        end else if (fire) begin
            state_d = shift_val;
        end
    end

    // State, valid and sticky seed error registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET_SEED;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             wrap;

    // A shift that lands back on the start value closes one full period
    always_comb begin
        wrap    = fire & ~seed_load & (shift_val == start_q);
        start_d = start_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (seed_load) begin
            start_d = load_val;
            cnt_d   = '0;
        end else if (fire) begin
            if (wrap) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Period tracking registers; start value restarts from the reset seed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q <= RESET_SEED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign period_cnt  = cnt_q;
    assign period_done = done_q;
`endif

    assign out_valid = valid_q;
    assign out_bit   = state_q[0];
    assign state     = state_q;
    assign seed_err  = err_q;

endmodule

// File: tb/tb_lfsr_fib_gen.sv
// Self-checking bench for lfsr_fib_gen (WIDTH=4, TAPS=4'h3, RESET_SEED=4'h8).
// The reference model keeps the register as a queue of output bits and
// extends the bit stream with the tap recurrence.
module tb_lfsr_fib_gen;

    localparam int unsigned W  = 4;
    localparam logic [3:0]  TP = 4'h3;
    localparam logic [3:0]  RS = 4'h8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       seed_load;
    logic [3:0] seed;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic [3:0] state;
    logic       seed_err;
`ifdef LFSR_PERIOD_CNT_EN
    logic [3:0] period_cnt;
    logic       period_done;
`endif

    lfsr_fib_gen #(
        .WIDTH      (W),
        .TAPS       (TP),
        .RESET_SEED (RS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seed_load (seed_load),
        .seed      (seed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .state     (state),
        .seed_err  (seed_err)
`ifdef LFSR_PERIOD_CNT_EN
        ,
        .period_cnt  (period_cnt),
        .period_done (period_done)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: win[i] is register bit i; the stream advances by popping bit 0
    bit         win[$];
    bit         m_valid;
    bit         m_err;
    logic [3:0] m_start;
    logic [3:0] m_cnt;
    bit         m_done;

    function automatic void init_win(input logic [3:0] v);
        win.delete();
        for (int i = 0; i < 4; i++) win.push_back(v[i]);
    endfunction

    function automatic logic [3:0] win_val();
        logic [3:0] v = '0;
        for (int i = 0; i < 4; i++) v = v + (4'(win[i]) << i);
        return v;
    endfunction

    function automatic void model_shift();
        bit nb = 1'b0;
        for (int i = 0; i < 4; i++) if (TP[i]) nb = nb ^ win[i];
        void'(win.pop_front());
        win.push_back(nb);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge
    task automatic step(input logic r, input logic e, input logic ld, input logic [3:0] sd,
                        input logic rdy);
        bit fire;
        rst_n     = r;
        en        = e;
        seed_load = ld;
        seed      = sd;
        out_ready = rdy;
        fire      = m_valid & rdy;
        @(posedge clk);
        m_done = 1'b0;
        if (!r) begin
            init_win(RS);
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_start = RS;
            m_cnt   = '0;
        end else begin
            if (ld) begin
                if (sd == 4'h0) begin
                    init_win(RS);
                    m_err   = 1'b1;
                    m_start = RS;
                end else begin
                    init_win(sd);
                    m_err   = 1'b0;
                    m_start = sd;
                end
                m_cnt = '0;
            end else if (fire) begin
                model_shift();
                if (win_val() == m_start) begin
                    m_cnt  = '0;
                    m_done = 1'b1;
                end else begin
                    m_cnt = m_cnt + 4'd1;
                end
            end
            m_valid = e & ~ld;
        end
        #1;
        check("state", 32'(state), 32'(win_val()));
        check("out_bit", 32'(out_bit), 32'(win[0]));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("seed_err", 32'(seed_err), 32'(m_err));
`ifdef LFSR_PERIOD_CNT_EN
        check("period_cnt", 32'(period_cnt), 32'(m_cnt));
        check("period_done", 32'(period_done), 32'(m_done));
`endif
    endtask

    logic [3:0] seq [15] = '{4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5, 4'hA,
                             4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h8};

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       r, e, ld, rdy;
        logic [3:0] sd;

        init_win(RS);
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_start = RS;
        m_cnt   = '0;
        m_done  = 1'b0;

        // Reset held for two cycles, then released idle
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        check("rst_state", 32'(state), 32'h8);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_err", 32'(seed_err), 32'h0);
        check("rst_bit", 32'(out_bit), 32'h0);

        // Free run: first valid one cycle after en, then one shift per cycle
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        check("first_valid", 32'(out_valid), 32'h1);
        check("first_hold", 32'(state), 32'h8);
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
            check("free_seq", 32'(state), 32'(seq[i]));
        end

        // Backpressure at state 9
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        check("bp_start", 32'(state), 32'h9);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
            check("bp_state", 32'(state), 32'h9);
            check("bp_bit", 32'(out_bit), 32'h1);
            check("bp_valid", 32'(out_valid), 32'h1);
        end
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        check("bp_release", 32'(state), 32'hC);

        // Zero seed rejected, then a good seed clears the flag
        step(1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
        check("zseed_state", 32'(state), 32'h8);
        check("zseed_err", 32'(seed_err), 32'h1);
        step(1'b1, 1'b1, 1'b1, 4'h5, 1'b1);
        check("seed5_state", 32'(state), 32'h5);
        check("seed5_err", 32'(seed_err), 32'h0);
        check("seed5_valid", 32'(out_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        check("seed5_hold", 32'(state), 32'h5);

        // Load/fire collision at state 6
        step(1'b1, 1'b0, 1'b1, 4'hC, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        check("coll_pre", 32'(state), 32'h6);
        step(1'b1, 1'b1, 1'b1, 4'hA, 1'b1);
        check("coll_state", 32'(state), 32'hA);
        check("coll_valid", 32'(out_valid), 32'h0);

        // Dropping en clears valid without shifting
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        check("en_drop_valid", 32'(out_valid), 32'h0);
        check("en_drop_state", 32'(state), 32'hA);

        // Reset mid-stream
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
        check("midrst_state", 32'(state), 32'h8);

`ifdef LFSR_PERIOD_CNT_EN
        // Full period from seed 3
        step(1'b1, 1'b0, 1'b1, 4'h3, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        check("per_cnt14", 32'(period_cnt), 32'd14);
        check("per_nodone", 32'(period_done), 32'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        check("per_done", 32'(period_done), 32'h1);
        check("per_cnt0", 32'(period_cnt), 32'd0);
        check("per_state", 32'(state), 32'h3);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        check("per_pulse", 32'(period_done), 32'h0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(63) != 0);
            e   = ($urandom_range(7) != 0);
            rdy = ($urandom_range(3) != 0);
            ld  = ($urandom_range(15) == 0);
            sd  = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15));
            step(r, e, ld, sd, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_fib_gen.md
Name: lfsr_fib_gen

Overview:
- Fibonacci LFSR pseudo-random bit generator.
- Its feedback is the XOR (half-adder sum) of the tapped state bits.
- Emits one bit per valid/ready handshake to the downstream half-adder/bit-serial datapath.
- Provides seed loading and zero-state (lock-up) protection.

Parameters:
- WIDTH, 8: LFSR state width, legal range 3..32.
- TAPS, 8'h1D: feedback mask; bit i set means state[i] is XORed into the feedback. The default implements x^8+x^6+x^5+x^4+1, period 255.
- RESET_SEED, 1: state after reset and after a rejected seed. Must be non-zero.

Ports:
- clk: in, 1. Clock; all logic is rising-edge.
- rst_n: in, 1. Reset: synchronous, active-low; one clock, clk, and reset rst_n.
- en: in, 1. Generator enable.
- seed_load: in, 1. Load seed into state this cycle.
- seed: in, WIDTH. Seed value.
- out_valid: out, 1. out_bit is valid.
- out_ready: in, 1. Consumer accepts out_bit.
- out_bit: out, 1. Current output bit, equal to state[0].
- state: out, WIDTH. Current LFSR register.
- seed_err: out, 1. Sticky flag: the last seed_load carried zero.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=RESET_SEED, out_valid=0, seed_err=0.
  - out_bit follows state[0] (RESET_SEED[0]).
  - The optional counter clears to 0.
- Feedback and shift:
  - fb = XOR-reduce(state & TAPS).
  - next = {fb, state[WIDTH-1:1]}, i.e. right shift.
  - out_bit = state[0], combinational from the register.
- Handshake:
  - fire = out_valid & out_ready.
  - On fire, state takes next at the same edge; the bit presented during the fire cycle is the one consumed.
  - out_valid is registered: out_valid <= en & ~seed_load.
  - This gives 1-cycle latency from en rising to the first valid bit.
- Throughput and stalls:
  - Throughput is 1 bit/cycle while en=1 and out_ready=1.
  - With out_ready=0 and out_valid=1: state, out_bit and out_valid hold.
  - Dropping en clears out_valid on the next edge. No shift happens at that edge unless fire occurs in the same cycle.
- Seed load:
  - seed_load has priority over fire.
  - If seed != 0: state=seed, seed_err=0.
  - If seed == 0: state=RESET_SEED, seed_err=1 (sticky until the next non-zero load or reset).
  - If seed_load and fire coincide, the presented bit counts as delivered and state takes the seed, not next.
  - out_valid is 0 in the cycle after any load.
- Lock-up: state can never become zero through shifting, because zero is unreachable from a non-zero state with a maximal TAPS. Zero is also blocked at load as described above.
- Reset mid-stream aborts the current bit; no partial state is retained.

Optional Feature:
- Macro: LFSR_PERIOD_CNT_EN.
- Defined:
  - Adds outputs period_cnt (WIDTH bits) and period_done (1 bit).
  - period_cnt increments on each fire and clears on reset or load.
  - period_done pulses for one cycle on the edge where a fire returns state to the start value (the last loaded seed, or RESET_SEED after reset). At that edge period_cnt clears to 0.
  - With the defaults, period_done pulses after 255 fires.
- Undefined: neither port exists and no counter logic is built.

Test Plan (WIDTH=4, TAPS=4'h3, RESET_SEED=4'h8 unless noted):
- Reset: hold rst_n=0 for 2 cycles, then release -> state=4'h8, out_valid=0, seed_err=0, out_bit=0.
- Free run: en=1, out_ready=1 for 15 cycles from 4'h8 -> state sequence 4,2,9,C,6,B,5,A,D,E,F,7,3,1,8. First out_valid appears 1 cycle after en.
- Backpressure: from state 4'h9, drop out_ready for 3 cycles -> state stays 4'h9, out_bit stays 1, out_valid stays 1. Raise out_ready -> next state 4'hC.
- Zero seed: seed_load=1, seed=0 -> state=4'h8, seed_err=1. Then seed_load with seed=4'h5 -> state=4'h5, seed_err=0, out_valid=0 in the following cycle.
- Load/fire collision: at state 4'h6 with out_ready=1, pulse seed_load with seed=4'hA -> state=4'hA, not 4'hB.
- LFSR_PERIOD_CNT_EN: load 4'h3, then 15 fires -> period_done pulses once with state back at 4'h3. period_cnt reads 14 before that fire and 0 after it.
